// File: rtl/execute_stage.sv
// Execute stage: computes the ALU result, flags and branch target for one operation
// and holds it in a single-entry output register behind a valid/ready handshake.
module execute_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_in,
    output logic        ready_in,
    input  logic [2:0]  ALUControl,
    input  logic [31:0] SrcA,
    input  logic [31:0] SrcB,
    input  logic [4:0]  RdE,
    input  logic        RegWriteE,
    input  logic        BranchE,
    input  logic [31:0] PCE,
    input  logic [31:0] ImmExtE,
    input  logic        flush,
    output logic        valid_out,
    input  logic        ready_out,
    output logic [31:0] ALUResultM,
    output logic [4:0]  RdM,
    output logic        RegWriteM,
    output logic        ZeroM,
    output logic        NegM,
    output logic        CarryM,
    output logic        OvfM,
    output logic        PCSrcM,
    output logic [31:0] PCTargetM,
    output logic [31:0] op_count
);

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_SLT = 3'b101
    } alu_op_e;

    alu_op_e     alu_op;
    logic        is_sub;
    logic [31:0] opb;
    logic [32:0] sum;
    logic        add_ovf;

    logic [31:0] res_c;
    logic        zero_c, neg_c, carry_c, ovf_c;

    logic        accept;
    logic        hand_off;

    logic        valid_q, valid_d;
    logic [31:0] res_q, res_d;
    logic [4:0]  rd_q, rd_d;
    logic        regw_q, regw_d;
    logic        zero_q, zero_d;
    logic        neg_q, neg_d;
    logic        carry_q, carry_d;
    logic        ovf_q, ovf_d;
    logic        pcsrc_q, pcsrc_d;
    logic [31:0] tgt_q, tgt_d;
    logic [31:0] cnt_q, cnt_d;

    assign alu_op  = alu_op_e'(ALUControl);
    assign is_sub  = (alu_op == ALU_SUB);
    // Subtraction reuses the adder as A + ~B + 1, so carry-out means "no borrow".
    assign opb     = is_sub ? ~SrcB : SrcB;
    assign sum     = {1'b0, SrcA} + {1'b0, opb} + {32'b0, is_sub};
    assign add_ovf = (SrcA[31] == opb[31]) && (sum[31] != SrcA[31]);

    always_comb begin
        res_c   = '0;
        zero_c  = 1'b0;
        neg_c   = 1'b0;
        carry_c = 1'b0;
        ovf_c   = 1'b0;
        case (alu_op)
            ALU_ADD, ALU_SUB: begin
                res_c   = sum[31:0];
                carry_c = sum[32];
                ovf_c   = add_ovf;
            end
            ALU_AND: res_c = SrcA & SrcB;
            ALU_OR:  res_c = SrcA | SrcB;
            ALU_SLT: res_c = {31'b0, ($signed(SrcA) < $signed(SrcB))};
            default: res_c = '0;
        endcase
        // Unassigned opcodes report no flags at all, not even Zero.
        if (alu_op inside {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT}) begin
            zero_c = (res_c == '0);
            neg_c  = res_c[31];
        end
    end

    assign ready_in = !valid_q || ready_out;
    assign accept   = valid_in && ready_in && !flush;
    assign hand_off = valid_q && ready_out && !flush;

    always_comb begin
        valid_d = valid_q;
        res_d   = res_q;
        rd_d    = rd_q;
        regw_d  = regw_q;
        zero_d  = zero_q;
        neg_d   = neg_q;
        carry_d = carry_q;
        ovf_d   = ovf_q;
        pcsrc_d = pcsrc_q;
        tgt_d   = tgt_q;
        cnt_d   = hand_off ? cnt_q + 32'd1 : cnt_q;

        if (flush) begin
            valid_d = 1'b0;
            regw_d  = 1'b0;
            pcsrc_d = 1'b0;
        end else if (accept) begin
            valid_d = 1'b1;
            res_d   = res_c;
            rd_d    = RdE;
            regw_d  = RegWriteE;
            zero_d  = zero_c;
            neg_d   = neg_c;
            carry_d = carry_c;
            ovf_d   = ovf_c;
            pcsrc_d = BranchE && zero_c;
            tgt_d   = PCE + ImmExtE;
        end else if (hand_off) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            res_q   <= '0;
            rd_q    <= '0;
            regw_q  <= 1'b0;
            zero_q  <= 1'b0;
            neg_q   <= 1'b0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            pcsrc_q <= 1'b0;
            tgt_q   <= '0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            res_q   <= res_d;
            rd_q    <= rd_d;
            regw_q  <= regw_d;
            zero_q  <= zero_d;
            neg_q   <= neg_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
            pcsrc_q <= pcsrc_d;
            tgt_q   <= tgt_d;
            cnt_q   <= cnt_d;
        end
    end

    assign valid_out  = valid_q;
    assign ALUResultM = res_q;
    assign RdM        = rd_q;
    assign RegWriteM  = regw_q;
    assign ZeroM      = zero_q;
    assign NegM       = neg_q;
    assign CarryM     = carry_q;
    assign OvfM       = ovf_q;
    assign PCSrcM     = pcsrc_q;
    assign PCTargetM  = tgt_q;
    assign op_count   = cnt_q;

endmodule

// File: tb/tb_execute_stage.sv
// Bench for execute_stage: directed vector table, hand-written stall/flush/reset
// sequences and a randomized run, all checked against an arithmetic reference model.
module tb_execute_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_in, ready_in;
    logic [2:0]  ALUControl;
    logic [31:0] SrcA, SrcB;
    logic [4:0]  RdE;
    logic        RegWriteE, BranchE;
    logic [31:0] PCE, ImmExtE;
    logic        flush;
    logic        valid_out, ready_out;
    logic [31:0] ALUResultM;
    logic [4:0]  RdM;
    logic        RegWriteM, ZeroM, NegM, CarryM, OvfM, PCSrcM;
    logic [31:0] PCTargetM, op_count;

    execute_stage dut (
        .clk(clk), .rst(rst), .valid_in(valid_in), .ready_in(ready_in),
        .ALUControl(ALUControl), .SrcA(SrcA), .SrcB(SrcB), .RdE(RdE),
        .RegWriteE(RegWriteE), .BranchE(BranchE), .PCE(PCE), .ImmExtE(ImmExtE),
        .flush(flush), .valid_out(valid_out), .ready_out(ready_out),
        .ALUResultM(ALUResultM), .RdM(RdM), .RegWriteM(RegWriteM),
        .ZeroM(ZeroM), .NegM(NegM), .CarryM(CarryM), .OvfM(OvfM),
        .PCSrcM(PCSrcM), .PCTargetM(PCTargetM), .op_count(op_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        valid;
        logic [31:0] res;
        logic [4:0]  rd;
        logic        regw, z, n, c, v, pcsrc;
        logic [31:0] tgt;
        logic [31:0] cnt;
    } model_t;

    typedef struct packed {
        logic [31:0] r;
        logic        z, n, c, v;
    } alu_t;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a, b, pc, imm;
        logic        br;
        logic [31:0] r;
        logic        z, n, c, v, pcsrc;
        logic [31:0] tgt;
    } vec_t;

    model_t      m;
    int unsigned errors = 0;
    int unsigned checks = 0;

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // Reference ALU using exact integer arithmetic on 64-bit values.
    function automatic alu_t alu_ref(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        alu_t        o;
        longint      sa, sb, exact;
        logic [63:0] ua, ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        o  = '0;
        case (op)
            3'b000: begin
                o.r   = a + b;
                o.c   = (ua + ub) > 64'h0000_0000_FFFF_FFFF;
                exact = sa + sb;
                o.v   = exact != longint'($signed(o.r));
            end
            3'b001: begin
                o.r   = a - b;
                o.c   = (a >= b);
                exact = sa - sb;
                o.v   = exact != longint'($signed(o.r));
            end
            3'b010: o.r = a & b;
            3'b011: o.r = a | b;
            3'b101: o.r = (sa < sb) ? 32'd1 : 32'd0;
            default: o.r = '0;
        endcase
        if (op inside {3'b000, 3'b001, 3'b010, 3'b011, 3'b101}) begin
            o.z = (o.r == 32'd0);
            o.n = o.r[31];
        end
        return o;
    endfunction

    task automatic check_all();
        chk1 ("valid_out", valid_out, m.valid);
        chk32("ALUResultM", ALUResultM, m.res);
        chk32("RdM", {27'b0, RdM}, {27'b0, m.rd});
        chk1 ("RegWriteM", RegWriteM, m.regw);
        chk1 ("ZeroM", ZeroM, m.z);
        chk1 ("NegM", NegM, m.n);
        chk1 ("CarryM", CarryM, m.c);
        chk1 ("OvfM", OvfM, m.v);
        chk1 ("PCSrcM", PCSrcM, m.pcsrc);
        chk32("PCTargetM", PCTargetM, m.tgt);
        chk32("op_count", op_count, m.cnt);
    endtask

    // Present inputs for one cycle, advance the model across the edge, check at the next negedge.
    task automatic drive(input logic vi, input logic ro, input logic fl, input logic [2:0] op,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] pc,
                         input logic [31:0] imm, input logic [4:0] rd, input logic rw, input logic br);
        alu_t e;
        logic can_take, acc, hand;
        valid_in = vi; ready_out = ro; flush = fl; ALUControl = op;
        SrcA = a; SrcB = b; PCE = pc; ImmExtE = imm; RdE = rd; RegWriteE = rw; BranchE = br;
        #1;
        can_take = !m.valid || ro;
        chk1("ready_in", ready_in, can_take);
        acc  = vi && can_take && !fl;
        hand = m.valid && ro;
        if (hand && !fl) m.cnt = m.cnt + 32'd1;
        if (fl) begin
            m.valid = 1'b0; m.regw = 1'b0; m.pcsrc = 1'b0;
        end else if (acc) begin
            e = alu_ref(op, a, b);
            m.valid = 1'b1; m.res = e.r; m.rd = rd; m.regw = rw;
            m.z = e.z; m.n = e.n; m.c = e.c; m.v = e.v;
            m.pcsrc = br && e.z;
            m.tgt = pc + imm;
        end else if (hand) begin
            m.valid = 1'b0;
        end
        @(negedge clk);
        check_all();
    endtask

    vec_t        vecs[12];
    logic [31:0] saved_cnt, saved_res;

    initial begin
        vecs[0]  = '{3'b000, 32'h7FFFFFFF, 32'h1,        32'h40,        32'h4,        1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h44};
        vecs[1]  = '{3'b001, 32'h5,        32'h5,        32'h100,       32'hFFFFFFF0, 1'b1, 32'h0,        1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'hF0};
        vecs[2]  = '{3'b101, 32'hFFFFFFFF, 32'h1,        32'h0,         32'h0,        1'b0, 32'h1,        1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
        vecs[3]  = '{3'b101, 32'h1,        32'hFFFFFFFF, 32'hFFFFFFFF,  32'h2,        1'b1, 32'h0,        1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h1};
        vecs[4]  = '{3'b010, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0,         32'h0,        1'b0, 32'hF000F000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0};
        vecs[5]  = '{3'b011, 32'h0,        32'h0,        32'h10,        32'h20,       1'b1, 32'h0,        1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h30};
        vecs[6]  = '{3'b100, 32'h5,        32'h5,        32'h1000,      32'h4,        1'b1, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h1004};
        vecs[7]  = '{3'b110, 32'hFFFFFFFF, 32'h1,        32'h0,         32'h0,        1'b1, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
        vecs[8]  = '{3'b111, 32'h80000000, 32'h80000000, 32'h8,         32'h8,        1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h10};
        vecs[9]  = '{3'b001, 32'h0,        32'h1,        32'h0,         32'h0,        1'b0, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0};
        vecs[10] = '{3'b001, 32'h80000000, 32'h1,        32'h0,         32'h0,        1'b0, 32'h7FFFFFFF, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0};
        vecs[11] = '{3'b000, 32'hFFFFFFFF, 32'h1,        32'h0,         32'h0,        1'b1, 32'h0,        1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0};

        m = '0;
        rst = 1'b1;
        valid_in = 1'b0; ready_out = 1'b0; flush = 1'b0; ALUControl = '0;
        SrcA = '0; SrcB = '0; PCE = '0; ImmExtE = '0; RdE = '0; RegWriteE = 1'b0; BranchE = 1'b0;
        repeat (2) @(negedge clk);
        check_all();
        chk1("reset_ready_in", ready_in, 1'b1);
        rst = 1'b0;
        #1;
        chk1("post_reset_ready_in", ready_in, 1'b1);

        // Directed vectors, issued back to back with the consumer always ready.
        for (int i = 0; i < 12; i++) begin
            drive(1'b1, 1'b1, 1'b0, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].pc, vecs[i].imm,
                  5'(i + 1), 1'b1, vecs[i].br);
            chk32($sformatf("vec%0d_res", i), ALUResultM, vecs[i].r);
            chk1 ($sformatf("vec%0d_zero", i), ZeroM, vecs[i].z);
            chk1 ($sformatf("vec%0d_neg", i), NegM, vecs[i].n);
            chk1 ($sformatf("vec%0d_carry", i), CarryM, vecs[i].c);
            chk1 ($sformatf("vec%0d_ovf", i), OvfM, vecs[i].v);
            chk1 ($sformatf("vec%0d_pcsrc", i), PCSrcM, vecs[i].pcsrc);
            chk32($sformatf("vec%0d_tgt", i), PCTargetM, vecs[i].tgt);
            chk32($sformatf("vec%0d_cnt", i), op_count, 32'(i));
        end

        // Stall: a held result stays frozen while a new op waits upstream.
        drive(1'b1, 1'b1, 1'b0, 3'b000, 32'd3, 32'd4, 32'h0, 32'h0, 5'd7, 1'b1, 1'b0);
        saved_cnt = op_count;
        saved_res = ALUResultM;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 1'b0, 3'b001, 32'd9, 32'd2, 32'h0, 32'h0, 5'd8, 1'b1, 1'b0);
            #1;
            chk1 ("stall_ready_in", ready_in, 1'b0);
            chk32("stall_res", ALUResultM, 32'd7);
            chk32("stall_cnt", op_count, saved_cnt);
        end
        drive(1'b1, 1'b1, 1'b0, 3'b011, 32'h0, 32'h0, 32'h0, 32'h0, 5'd9, 1'b1, 1'b1);
        chk32("release_cnt", op_count, saved_cnt + 32'd1);
        chk1 ("release_valid", valid_out, 1'b1);
        chk1 ("release_pcsrc", PCSrcM, 1'b1);

        // Flush with a held op and a new op presented.
        saved_cnt = op_count;
        drive(1'b1, 1'b1, 1'b1, 3'b000, 32'd1, 32'd1, 32'h0, 32'h0, 5'd10, 1'b1, 1'b1);
        chk1 ("flush_valid", valid_out, 1'b0);
        chk1 ("flush_regw", RegWriteM, 1'b0);
        chk1 ("flush_pcsrc", PCSrcM, 1'b0);
        chk32("flush_cnt", op_count, saved_cnt);
        chk32("flush_keeps_data", ALUResultM, saved_res & 32'h0);

        // Asynchronous reset between edges during a stall.
        drive(1'b1, 1'b1, 1'b0, 3'b000, 32'd20, 32'd22, 32'h4, 32'h4, 5'd11, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 3'b000, 32'd1, 32'd2, 32'h0, 32'h0, 5'd12, 1'b1, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        m = '0;
        check_all();
        chk1 ("async_rst_ready_in", ready_in, 1'b1);
        chk32("async_rst_cnt", op_count, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk1("rst_release_ready_in", ready_in, 1'b1);

        // Randomized traffic against the reference model.
        for (int i = 0; i < 400; i++) begin
            logic [31:0] a, b;
            a = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
            b = ($urandom_range(0, 3) == 0) ? a : $urandom;
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0,
                  3'($urandom_range(0, 7)), a, b, $urandom, $urandom,
                  5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/execute_stage.md
EXECUTE_STAGE -- requirements
Module: execute_stage

Interface
REQ-001 SHALL have ports: clk  input  1  rising-edge clock.
REQ-002 SHALL have: rst  input  1  asynchronous, active-high reset.
REQ-003 SHALL have: valid_in  input  1  upstream (decode) presents an operation.
REQ-004 SHALL have: ready_in  output  1  stage can accept an operation this cycle.
REQ-005 SHALL have: ALUControl  input  3  operation code from the ALU decoder.
REQ-006 SHALL have: SrcA, SrcB  input  32 each  operands.
REQ-007 SHALL have: RdE  input  5; RegWriteE  input  1; BranchE  input  1  destination, write-enable, branch flag.
REQ-008 SHALL have: PCE  input  32; ImmExtE  input  32  PC and sign-extended immediate.
REQ-009 SHALL have: flush  input  1  discard held and incoming operations.
REQ-010 SHALL have: valid_out  output  1; ready_out  input  1  downstream (memory) handshake.
REQ-011 SHALL have: ALUResultM  output  32; RdM  output  5; RegWriteM  output  1  registered results.
REQ-012 SHALL have: ZeroM, NegM, CarryM, OvfM  output  1 each  registered flags.
REQ-013 SHALL have: PCSrcM  output  1; PCTargetM  output  32  registered branch decision and target.
REQ-014 SHALL have: op_count  output  32  number of operations handed downstream.

Function
REQ-015 SHALL hold a single-entry output register; ready_in = !valid_out | ready_out (combinational).
REQ-016 SHALL accept on a rising edge with valid_in & ready_in & !flush; results are visible on the outputs the next cycle (latency 1).
REQ-017 SHALL decode ALUControl: 000 add, 001 sub (A + ~B + 1), 010 AND, 011 OR, 101 signed set-less-than (bit0 only, upper 31 bits zero); 100, 110, 111 produce result 0 with all flags 0.
REQ-018 SHALL compute add/sub in 33 bits; CarryM = bit 32 (for sub, 1 means no borrow); OvfM = signed overflow of add/sub, 0 for other ops.
REQ-019 SHALL set ZeroM = (result == 0) and NegM = result[31] for every valid op, including logic ops and slt.
REQ-020 SHALL compute PCTargetM = PCE + ImmExtE modulo 2^32, with wrap-around and no flag; PCSrcM = BranchE & Zero of the same op.
REQ-021 SHALL drop valid_out when ready_out=1 and no new accept occurs in that cycle; SHALL support back-to-back accept+hand-off in the same cycle (one op per cycle throughput).
REQ-022 SHALL hold all registered outputs stable while valid_out=1 and ready_out=0 (stall); ready_in=0 during the stall.
REQ-023 SHALL, on flush, clear valid_out, RegWriteM and PCSrcM at the next edge and ignore valid_in that cycle; flush takes priority over accept and stall.
REQ-024 SHALL increment op_count by 1 on each edge with valid_out & ready_out & !flush; wraps 0xFFFFFFFF -> 0.
REQ-025 SHALL leave data registers unchanged (not zeroed) when no accept occurs; only valid_out, RegWriteM and PCSrcM gate consumer action.

Reset
REQ-026 SHALL, on rst high, immediately (no clock) force valid_out=0, RegWriteM=0, PCSrcM=0, ALUResultM=0, RdM=0, all flags 0, PCTargetM=0, op_count=0.
REQ-027 SHALL give ready_in=1 while reset is held and on the first cycle after release.
REQ-028 SHALL lose any in-flight op when reset asserts mid-operation; no hand-off is counted for it.

Verification
REQ-029 add: SrcA=0x7FFFFFFF, SrcB=1, ALUControl=000 -> next cycle ALUResultM=0x80000000, OvfM=1, NegM=1, CarryM=0, ZeroM=0.
REQ-030 sub branch: SrcA=SrcB=5, ALUControl=001, BranchE=1, PCE=0x100, ImmExtE=0xFFFFFFF0 -> ALUResultM=0, ZeroM=1, CarryM=1, PCSrcM=1, PCTargetM=0xF0.
REQ-031 slt: SrcA=0xFFFFFFFF, SrcB=1, ALUControl=101 -> ALUResultM=1; reversed operands -> 0.
REQ-032 stall: hold ready_out=0 for 3 cycles with valid_in=1 -> outputs frozen, ready_in=0, op_count unchanged; release -> op_count +1, next op accepted the same cycle.
REQ-033 flush: flush=1 with valid_out=1 and valid_in=1 -> next cycle valid_out=0, RegWriteM=0, PCSrcM=0, op_count unchanged.
REQ-034 reset: assert rst asynchronously between edges during a stall -> outputs zero before next edge, op_count=0, ready_in=1.
